// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU.
// Op encoding matches the alu1bit slice.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: NOR, XOR, full add/sub.
// a_ns=1 inverts b on the arithmetic path.
module alu1bit
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  input  op_t  op,
  output logic s,
  output logic cout
);

  logic bx;

  always_comb begin
    bx   = b ^ a_ns;
    s    = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      OP_ADD, OP_SUB: begin
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
      end
      default: begin
        s    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial N-bit ALU: one alu1bit slice, LSB first,
// one bit per cycle, done pulse with result and flags.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  op_t              op_q, op_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last;
  logic             s;
  logic             co;
  logic [WIDTH-1:0] res_sh;

  alu1bit u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .a_ns (op_q[0]),
    .op   (op_q),
    .s    (s),
    .cout (co)
  );

  assign accept = start & (state_q != S_RUN);
  assign last   = (state_q == S_RUN) &&
                  (cnt_q == CW'(WIDTH - 1));
  // New bit enters at the MSB; works for WIDTH=1 too.
  assign res_sh = (res_q >> 1) |
                  (WIDTH'(s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d   = a;
      b_d   = b;
      op_d  = op_t'(op);
      cnt_d = '0;
      cy_d  = op[1] & op[0];
      res_d = '0;
    end else if (state_q == S_RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = res_sh;
      cy_d  = co;
      if (!last) cnt_d = cnt_q + CW'(1);
      if (last) begin
        carry_d = co;
        // cy_q is still the carry into the MSB here
        ovf_d   = op_q[1] & (cy_q ^ co);
        zero_d  = (res_sh == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_NOR;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready  = (state_q != S_RUN);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: directed WIDTH=8,
// reference-model random at WIDTH=1 and WIDTH=16.
module tb_alu_serial;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic [31:0] t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, got none expected event", nm);
  endtask

  function automatic exp_t model(input int w,
                                 input logic [1:0] op,
                                 input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    logic [64:0] mask;
    logic [64:0] sum;
    mask = (65'd1 << w) - 65'd1;
    e = '0;
    sum = '0;
    case (op)
      2'b00: e.r = ~(a | b) & mask[63:0];
      2'b01: e.r = (a ^ b) & mask[63:0];
      2'b10: begin
        sum = {1'b0, a} + {1'b0, b};
        e.v = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
      end
      default: begin
        sum = {1'b0, a} + {1'b0, ~b & mask[63:0]} + 65'd1;
        e.v = (a[w-1] != b[w-1]) && (sum[w-1] != a[w-1]);
      end
    endcase
    if (op[1]) begin
      e.c = sum[w];
      e.r = sum[63:0] & mask[63:0];
    end
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  // ---------------- WIDTH=8 directed instance
  logic       rst_n;
  logic       start8;
  logic [1:0] op8;
  logic [7:0] a8, b8, res8;
  logic       rdy8, busy8, done8, c8, v8, z8;
  exp_t       sb8[$];

  alu_serial #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8),
    .a(a8), .b(b8), .ready(rdy8), .busy(busy8),
    .done(done8), .result(res8), .carry(c8),
    .ovf(v8), .zero(z8)
  );

  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) begin
        chk("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        chk("w8_result", {res8, c8, v8, z8},
            {e.r[7:0], e.c, e.v, e.z});
        chk("w8_latency", cyc - int'(e.t0), 8);
      end
    end
  end

  // caller is at a negedge
  task automatic issue8(input logic [1:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] r,
                        input logic c, input logic v,
                        input logic z);
    exp_t e;
    int t;
    t = 0;
    while (!rdy8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy8) tmo("w8_ready");
    e = '0;
    e.r = 64'(r);
    e.c = c;
    e.v = v;
    e.z = z;
    e.t0 = 32'(cyc + 1);
    sb8.push_back(e);
    op8 = op;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8();
    int t;
    t = 0;
    while (!done8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done8) tmo("w8_done");
  endtask

  task automatic drain8();
    int t;
    t = 0;
    while (sb8.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb8.size() != 0) tmo("w8_drain");
    @(negedge clk);
  endtask

  // ---------------- random instances, WIDTH=1 and 16
  logic rst_r;
  bit   rnd_done [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 1 : 16;
    logic         start_r;
    logic [1:0]   op_r;
    logic [W-1:0] a_r, b_r, res_r;
    logic         rdy_r, busy_r, done_r, c_r, v_r, z_r;
    exp_t         q[$];

    alu_serial #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_r), .start(start_r),
      .op(op_r), .a(a_r), .b(b_r), .ready(rdy_r),
      .busy(busy_r), .done(done_r), .result(res_r),
      .carry(c_r), .ovf(v_r), .zero(z_r)
    );

    always @(negedge clk) begin
      if (done_r) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rnd_result", {64'(res_r), c_r, v_r, z_r},
              {e.r, e.c, e.v, e.z});
          chk("rnd_latency", cyc - int'(e.t0), W);
        end
      end
    end

    initial begin
      exp_t e;
      int t;
      logic [63:0] ra, rb;
      start_r = 1'b0;
      op_r = '0;
      a_r = '0;
      b_r = '0;
      rnd_done[gi] = 1'b0;
      @(posedge rst_r);
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        t = 0;
        while (!rdy_r && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!rdy_r) tmo("rnd_ready");
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        op_r = 2'($urandom_range(0, 3));
        a_r = ra[W-1:0];
        b_r = rb[W-1:0];
        e = model(W, op_r, 64'(a_r), 64'(b_r));
        e.t0 = 32'(cyc + 1);
        q.push_back(e);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
      end
      t = 0;
      while (q.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0) tmo("rnd_drain");
      rnd_done[gi] = 1'b1;
    end
  end

  // ---------------- directed sequence
  initial begin
    int t;
    rst_n = 1'b0;
    rst_r = 1'b0;
    start8 = 1'b0;
    op8 = 2'b00;
    a8 = '0;
    b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {res8, c8, v8, z8, done8, busy8, rdy8},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    rst_r = 1'b1;
    @(negedge clk);

    issue8(2'b10, 8'h7F, 8'h01, 8'h80, 0, 1, 0);
    drain8();
    issue8(2'b11, 8'h05, 8'h05, 8'h00, 1, 0, 1);
    drain8();
    issue8(2'b11, 8'h00, 8'h01, 8'hFF, 0, 0, 0);
    drain8();
    issue8(2'b00, 8'hF0, 8'h0F, 8'h00, 0, 0, 1);
    drain8();
    issue8(2'b01, 8'hAA, 8'hFF, 8'h55, 0, 0, 0);
    drain8();

    // start during RUN must be ignored
    issue8(2'b10, 8'h12, 8'h34, 8'h46, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("busy_in_run", busy8, 1);
    op8 = 2'b11;
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain8();

    // back-to-back start in the DONE cycle
    issue8(2'b01, 8'h0F, 8'hFF, 8'hF0, 0, 0, 0);
    wait_done8();
    issue8(2'b10, 8'h80, 8'h80, 8'h00, 1, 1, 1);
    chk("b2b_busy", {busy8, done8}, {1'b1, 1'b0});
    drain8();

    // reset in the middle of RUN aborts the op
    issue8(2'b10, 8'h01, 8'h01, 8'h02, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb8.delete();
    #1;
    chk("abort_state", {res8, c8, v8, z8, done8, busy8, rdy8},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    chk("abort_hold", {res8, c8, v8, z8, done8, busy8, rdy8},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", {done8, busy8}, {1'b0, 1'b0});
    issue8(2'b10, 8'hFF, 8'h01, 8'h00, 1, 0, 1);
    drain8();

    t = 0;
    while (!(rnd_done[0] && rnd_done[1]) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (!(rnd_done[0] && rnd_done[1])) tmo("rnd_finish");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
